// File: rtl/word_byte_serializer.sv
// word_byte_serializer
// Accepts a 32-bit word (1..4 valid bytes) from a valid/ready producer and
// emits it one byte per accepted transfer on a byte-wide valid/ready port.
// Byte order is selected at elaboration time by MSB_FIRST. A new word can be
// loaded on the same cycle the last byte of the current word transfers, so
// back-to-back words stream without an idle cycle.
module word_byte_serializer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_len,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_word;
  logic [31:0] w_word_nxt;
  logic [1:0]  r_len;
  logic [1:0]  w_len_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;

  logic [1:0]  w_lane;
  logic        w_last;
  logic        w_load;
  logic        w_xfer;

  // Lane 0 is [31:24] and lane 3 is [7:0].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Which lane the current index points at, depending on byte order.
  assign w_lane = MSB_FIRST ? r_idx : (2'd3 - r_idx);

  // The final byte of the word is the one whose index reaches the length.
  assign w_last = (r_state == ST_SEND) && (r_idx == r_len);

  // Output decode: everything except in_ready comes from registers only.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_last  = w_last;
        out_byte  = lane_byte(r_word, w_lane);
        in_ready  = w_last & out_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign busy   = out_valid;
  assign w_load = in_valid & in_ready;
  assign w_xfer = out_valid & out_ready;

  // Next-state: a load wins (including the reload on the last transfer),
  // otherwise a transfer advances the index or returns to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    if (w_load) begin
      w_state_nxt = ST_SEND;
      w_word_nxt  = in_data;
      w_len_nxt   = in_len;
      w_idx_nxt   = 2'd0;
    end else if (w_xfer) begin
      if (w_last) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_idx_nxt = r_idx + 2'd1;
      end
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_word  <= 32'h0000_0000;
      r_len   <= 2'd0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Bench for word_byte_serializer: two instances (MSB-first and LSB-first)
// share the same stimulus; a scoreboard queue holds the expected bytes of
// the word in flight for both byte orders.
module tb_word_byte_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_len;
  logic        out_ready;

  logic        m_in_ready, m_out_valid, m_out_last, m_busy;
  logic [7:0]  m_out_byte;
  logic        l_in_ready, l_out_valid, l_out_last, l_busy;
  logic [7:0]  l_out_byte;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] bm;
    logic [7:0] bl;
    logic       last;
  } sb_t;

  sb_t sb[$];

  word_byte_serializer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_len(in_len), .in_ready(m_in_ready), .out_valid(m_out_valid),
    .out_byte(m_out_byte), .out_last(m_out_last), .out_ready(out_ready),
    .busy(m_busy)
  );

  word_byte_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_len(in_len), .in_ready(l_in_ready), .out_valid(l_out_valid),
    .out_byte(l_out_byte), .out_last(l_out_last), .out_ready(out_ready),
    .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected byte stream of a freshly loaded word.
  task automatic push_word(input logic [31:0] d, input logic [1:0] len);
    logic [7:0] lanes [4];
    sb_t e;
    lanes[0] = d[31:24];
    lanes[1] = d[23:16];
    lanes[2] = d[15:8];
    lanes[3] = d[7:0];
    for (int i = 0; i <= int'(len); i++) begin
      e.bm   = lanes[i];
      e.bl   = lanes[3-i];
      e.last = (i == int'(len));
      sb.push_back(e);
    end
  endtask

  // One clock: compare outputs mid-cycle, then update the model at the edge.
  task automatic cycle();
    logic exp_valid, exp_ready, xfer, load;
    sb_t  e;
    @(negedge clk);
    exp_valid = (sb.size() != 0);
    if (exp_valid) e = sb[0];
    else begin
      e.bm = 8'h00; e.bl = 8'h00; e.last = 1'b0;
    end
    check("msb_out_valid", {31'd0, m_out_valid}, {31'd0, exp_valid});
    check("msb_out_byte",  {24'd0, m_out_byte},  {24'd0, e.bm});
    check("msb_out_last",  {31'd0, m_out_last},  {31'd0, e.last});
    check("msb_busy",      {31'd0, m_busy},      {31'd0, exp_valid});
    check("lsb_out_valid", {31'd0, l_out_valid}, {31'd0, exp_valid});
    check("lsb_out_byte",  {24'd0, l_out_byte},  {24'd0, e.bl});
    check("lsb_out_last",  {31'd0, l_out_last},  {31'd0, e.last});
    exp_ready = !exp_valid || (e.last && out_ready);
    if (rst_n) begin
      check("msb_in_ready", {31'd0, m_in_ready}, {31'd0, exp_ready});
      check("lsb_in_ready", {31'd0, l_in_ready}, {31'd0, exp_ready});
    end
    xfer = exp_valid && out_ready;
    load = in_valid && exp_ready;
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (xfer) void'(sb.pop_front());
      if (load) push_word(in_data, in_len);
    end
    #1;
  endtask

  // Run until the word in flight has fully drained, with a cycle budget.
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      cycle();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic load_word(input logic [31:0] d, input logic [1:0] len);
    in_valid = 1'b1;
    in_data  = d;
    in_len   = len;
    cycle();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0000_0000;
    in_len    = 2'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state / idle.
    cycle();

    // Full word, both byte orders.
    load_word(32'h1234_5678, 2'd3);
    drain();
    cycle();

    // Two-byte and one-byte partial words.
    load_word(32'hAABB_CCDD, 2'd1);
    drain();
    cycle();
    load_word(32'h0102_0304, 2'd0);
    drain();
    cycle();

    // Backpressure while the second byte is presented.
    load_word(32'h1234_5678, 2'd3);
    cycle();
    out_ready = 1'b0;
    repeat (3) cycle();
    out_ready = 1'b1;
    drain();
    cycle();

    // Back-to-back words: producer holds in_valid; second word changes
    // in_data right after the first load, so it is only taken on the
    // last-byte transfer.
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_len   = 2'd3;
    cycle();
    in_data  = 32'hCAFE_F00D;
    repeat (4) cycle();
    in_valid = 1'b0;
    drain();
    cycle();

    // Reset mid-word after the second byte transfers.
    load_word(32'h1234_5678, 2'd3);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
